// File: rtl/adder_share_arbiter_if.sv
// Request/result bundle for adder_share_arbiter: two operand ports in, one result port out.
// The slave modport is the arbiter side; the master modport is the producer/consumer side.
interface adder_share_arbiter_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// One WIDTH-bit adder shared by two requesters under round-robin arbitration,
// feeding a single-entry result register tagged with the requester ID.
module adder_share_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_share_arbiter_if.slave bus
);

  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             last_q, last_d;

  logic             can_accept;
  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SW-1:0]    add_res;

  // Grant: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    gnt_valid  = bus.req0_valid | bus.req1_valid;
    gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    can_accept = (state_q == EMPTY) || bus.res_ready;
    accept     = rst_n && can_accept && gnt_valid;
    op_a       = gnt_id ? bus.req1_a : bus.req0_a;
    op_b       = gnt_id ? bus.req1_b : bus.req0_b;
    add_res    = SW'(op_a) + SW'(op_b);
  end

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept &&  gnt_id;

  // Next state: accept loads (even while draining); drain alone empties; fields otherwise hold.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    last_d  = last_q;

    if (accept) begin
      state_d = FULL;
      sum_d   = add_res[WIDTH-1:0];
      cout_d  = add_res[WIDTH];
      id_d    = gnt_id;
      last_d  = gnt_id;
    end else if (state_q == FULL && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.busy      = (state_q == FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder (sum plus carry-out) between two requesters.
- Round-robin arbitration, valid/ready handshake on each request port, single-entry registered result with the requester ID.
- Sits between two operand producers and a single downstream result consumer.

Parameters:
- WIDTH, 4, operand and sum width in bits; carry-out is one extra bit.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; sampled on rising edge of clk
- req0_valid  in  1  requester 0 has operands
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_ready  out  1  requester 0 operands accepted this cycle
- req1_valid  in  1  requester 1 has operands
- req1_a  in  WIDTH  requester 1 operand A
- req1_b  in  WIDTH  requester 1 operand B
- req1_ready  out  1  requester 1 operands accepted this cycle
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  consumer takes result this cycle
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH
- res_cout  out  1  carry-out of a+b
- res_id  out  1  requester that produced the result
- busy  out  1  equals res_valid

Behaviour:
- Reset (rst_n low at clk edge): res_valid=0, res_sum=0, res_cout=0, res_id=0, last_grant=1. Reset clears any held, undrained result; request ports see ready=0 during reset.
- States: EMPTY (res_valid=0) and FULL (res_valid=1).
- can_accept = !res_valid OR (res_valid AND res_ready).
- Grant, combinational:
  - Only reqN_valid set: grant N.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- reqN_ready = can_accept AND grant==N. At most one ready is high per cycle. ready may depend combinationally on valid; valid must not depend on ready.
- Accept when reqN_valid AND reqN_ready. At the next edge:
  - {res_cout,res_sum} <= reqN_a + reqN_b, computed at WIDTH+1 bits, no truncation of carry.
  - res_id <= N, res_valid <= 1, last_grant <= N.
- Latency: result is visible the cycle after accept. Throughput is 1 per cycle when res_ready is held high.
- Drain without accept (res_valid AND res_ready, no request valid): res_valid <= 0 next edge. res_sum, res_cout and res_id hold their last values.
- Simultaneous drain and accept: the new result replaces the old one at the same edge, and res_valid stays 1.
- FULL with res_ready=0: both readys are 0. Result fields are stable until taken. last_grant does not change.
- last_grant updates only on an accept, never on idle cycles.
- Fairness: with both requesters continuously valid and res_ready=1, grants alternate 0,1,0,1…
- Boundary: a=b=2^WIDTH-1 gives sum=2^WIDTH-2, cout=1. a=b=0 gives 0,0.

Test Plan:
- Reset, then req0 only with a=4'h3, b=4'h4, res_ready=1 -> req0_ready=1 in the same cycle. Next cycle: res_valid=1, res_sum=4'h7, res_cout=0, res_id=0.
- Both valid from the cycle after reset, req0 (F,F), req1 (8,8), res_ready=1 -> first grant 0 (sum E, cout 1), then 1 (sum 0, cout 1), alternating for 8 cycles.
- Backpressure: res_ready=0 after one accept (2+5) with req1 valid -> res_sum holds 7 and req1_ready=0 for 5 cycles. Raise res_ready -> req1 accepted in that same cycle and its result appears the next cycle.
- Drain with no requests -> res_valid falls after one edge; res_sum retains its last value.
- Assert rst_n=0 for one cycle while FULL and res_ready=0 -> res_valid=0, res_sum=0 next edge. The first grant after reset goes to req0 even if req1 was granted last before reset.
- Exhaustive: all 256 (a,b) pairs on req1 -> {res_cout,res_sum}==a+b for every pair.
